// File: rtl/carfield_addr_map_rt.sv
// Runtime-programmable address-map decoder: NumRules base/size/target rules in registers,
// a 32-bit config port, and a one-stage valid/ready decode pipeline with a miss counter.
module carfield_addr_map_rt #(
  parameter int unsigned NumRules   = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned NumTargets = 8,
  parameter int unsigned DefaultIdx = 0,
  localparam int unsigned TgtW      = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_we_i,
  input  logic [11:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [TgtW-1:0]      out_idx_o,
  output logic                 out_err_o,
  output logic                 locked_o
);

  localparam int unsigned HiW = AddrWidth - 32;

  logic [AddrWidth-1:0] base_q [NumRules];
  logic [AddrWidth-1:0] size_q [NumRules];
  logic [TgtW-1:0]      tgt_q  [NumRules];
  logic [NumRules-1:0]  en_q;
  logic                 lock_q;
  logic [15:0]          miss_cnt_q;

  logic                 out_valid_q, out_err_q;
  logic [TgtW-1:0]      out_idx_q;
  logic                 cfg_rvalid_q, cfg_err_q;
  logic [31:0]          cfg_rdata_q;

  // Config access decode
  logic [5:0]           rule_idx;
  logic [2:0]           word_sel;
  logic [AddrWidth-1:0] sel_base, sel_size;
  logic [TgtW-1:0]      sel_tgt;
  logic                 sel_en;
  logic [31:0]          rd_data;
  logic                 acc_err, wr_rule, wr_lock, wr_miss;

  assign rule_idx = cfg_addr_i[10:5];
  assign word_sel = cfg_addr_i[4:2];

  always_comb begin
    sel_base = '0;
    sel_size = '0;
    sel_tgt  = '0;
    sel_en   = 1'b0;
    for (int r = 0; r < NumRules; r++) begin
      if (rule_idx == 6'(r)) begin
        sel_base = base_q[r];
        sel_size = size_q[r];
        sel_tgt  = tgt_q[r];
        sel_en   = en_q[r];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    acc_err = 1'b0;
    wr_rule = 1'b0;
    wr_lock = 1'b0;
    wr_miss = 1'b0;
    if (cfg_addr_i[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end else if (!cfg_addr_i[11]) begin
      if (32'(rule_idx) >= NumRules) begin
        acc_err = 1'b1;
      end else begin
        unique case (word_sel)
          3'd0:    rd_data = sel_base[31:0];
          3'd1:    rd_data = 32'(sel_base[AddrWidth-1:32]);
          3'd2:    rd_data = sel_size[31:0];
          3'd3:    rd_data = 32'(sel_size[AddrWidth-1:32]);
          3'd4:    begin
            rd_data[0]        = sel_en;
            rd_data[8 +: TgtW] = sel_tgt;
          end
          default: acc_err = 1'b1;
        endcase
        // Rule registers stay readable once locked; only writes are refused.
        if (!acc_err && cfg_we_i) begin
          if (lock_q) acc_err = 1'b1;
          else        wr_rule = 1'b1;
        end
      end
    end else begin
      unique case (cfg_addr_i[10:0])
        11'h000: begin
          rd_data[0] = lock_q;
          wr_lock    = cfg_we_i;
        end
        11'h004: begin
          rd_data[15:0] = miss_cnt_q;
          wr_miss       = cfg_we_i;
        end
        11'h008: begin
          rd_data = NumRules;
          acc_err = cfg_we_i;
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (cfg_we_i || acc_err) rd_data = '0;
    wr_rule = wr_rule & cfg_valid_i;
    wr_lock = wr_lock & cfg_valid_i;
    wr_miss = wr_miss & cfg_valid_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRules; r++) begin
        base_q[r] <= '0;
        size_q[r] <= '0;
        tgt_q[r]  <= '0;
      end
      en_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      if (wr_lock && cfg_wdata_i[0]) lock_q <= 1'b1;
      for (int r = 0; r < NumRules; r++) begin
        if (wr_rule && rule_idx == 6'(r)) begin
          unique case (word_sel)
            3'd0: base_q[r][31:0]           <= cfg_wdata_i;
            3'd1: base_q[r][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
            3'd2: size_q[r][31:0]           <= cfg_wdata_i;
            3'd3: size_q[r][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
            3'd4: begin
              en_q[r]  <= cfg_wdata_i[0];
              tgt_q[r] <= cfg_wdata_i[8 +: TgtW];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_rvalid_q <= cfg_valid_i;
      cfg_rdata_q  <= cfg_valid_i ? rd_data : '0;
      cfg_err_q    <= cfg_valid_i & acc_err;
    end
  end

  // Address decode: lowest matching index wins; limit compared in AddrWidth+1 bits
  logic            hit, dec_err;
  logic [TgtW-1:0] hit_tgt, dec_idx;

  always_comb begin
    hit     = 1'b0;
    hit_tgt = '0;
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (en_q[r] && (size_q[r] != '0) && (in_addr_i >= base_q[r]) &&
          ({1'b0, in_addr_i} < ({1'b0, base_q[r]} + {1'b0, size_q[r]}))) begin
        hit     = 1'b1;
        hit_tgt = tgt_q[r];
      end
    end
    dec_err = !hit || (32'(hit_tgt) >= NumTargets);
    dec_idx = dec_err ? TgtW'(DefaultIdx) : hit_tgt;
  end

  logic fire;
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign fire       = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_idx_q   <= dec_idx;
      out_err_q   <= dec_err;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (wr_miss) begin
      miss_cnt_q <= '0;
    end else if (fire && dec_err && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign cfg_ready_o  = 1'b1;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;
  assign out_valid_o  = out_valid_q;
  assign out_idx_o    = out_idx_q;
  assign out_err_o    = out_err_q;
  assign locked_o     = lock_q;

endmodule

// File: tb/tb_carfield_addr_map_rt.sv
// Directed bench for carfield_addr_map_rt: register map, decode priority, backpressure,
// lock behaviour and miss-counter saturation.
module tb_carfield_addr_map_rt;

  localparam int unsigned AW = 48;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_we = 1'b0;
  logic [11:0]   cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          cfg_ready, cfg_rvalid, cfg_err;
  logic [31:0]   cfg_rdata;
  logic          in_valid = 1'b0, in_ready;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid, out_ready = 1'b1, out_err, locked;
  logic [TW-1:0] out_idx;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_out    = 0;
  int unsigned n0;

  always #5 clk = ~clk;

  carfield_addr_map_rt dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_idx_o    (out_idx),
    .out_err_o    (out_err),
    .locked_o     (locked)
  );

  always @(posedge clk) if (!rst && out_valid && out_ready) n_out++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic err);
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    check("cfg_rvalid", 64'(cfg_rvalid), 64'd1);
    rd  = cfg_rdata;
    err = cfg_err;
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] data,
                    input logic exp_err);
    logic [31:0] rd;
    logic        err;
    cfg(1'b1, addr, data, rd, err);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_rdata"}, 64'(rd), 64'd0);
  endtask

  task automatic wr_ok(input logic [11:0] addr, input logic [31:0] data);
    wr("wr", addr, data, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    logic [31:0] d;
    logic        err;
    cfg(1'b0, addr, 32'd0, d, err);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_rdata"}, 64'(d), 64'(exp_data));
  endtask

  task automatic dec(input string tag, input logic [AW-1:0] addr, input logic [TW-1:0] exp_idx,
                     input logic exp_err);
    in_valid  = 1'b1;
    in_addr   = addr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_idx"}, 64'(out_idx), 64'(exp_idx));
    check({tag, "_err"}, 64'(out_err), 64'(exp_err));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_cfg_rvalid", 64'(cfg_rvalid), 64'd0);
    check("rst_cfg_rdata", 64'(cfg_rdata), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty table, global registers and access errors
    rd("num_rules", 12'h808, 32'd8, 1'b0);
    dec("empty", 48'h1234, 3'd0, 1'b1);
    rd("miss_one", 12'h804, 32'd1, 1'b0);
    wr("wr_num_rules", 12'h808, 32'd5, 1'b1);
    rd("unmapped_glb", 12'h900, 32'd0, 1'b1);
    rd("rule_oob", 12'h100, 32'd0, 1'b1);
    rd("rule_hole", 12'h014, 32'd0, 1'b1);
    rd("misaligned", 12'h002, 32'd0, 1'b1);
    wr("wr_rule_oob", 12'h100, 32'h1, 1'b1);

    // Two adjacent rules
    wr_ok(12'h000, 32'h7800_0000); wr_ok(12'h004, 32'h0);
    wr_ok(12'h008, 32'h0020_0000); wr_ok(12'h00C, 32'h0);
    wr_ok(12'h010, 32'h0000_0201);
    wr_ok(12'h020, 32'h7820_0000); wr_ok(12'h024, 32'h0);
    wr_ok(12'h028, 32'h0020_0000); wr_ok(12'h02C, 32'h0);
    wr_ok(12'h030, 32'h0000_0301);
    rd("rule0_ctrl", 12'h010, 32'h0000_0201, 1'b0);
    rd("rule1_base", 12'h020, 32'h7820_0000, 1'b0);
    dec("r0_last", 48'h781F_FFFF, 3'd2, 1'b0);
    dec("r1_first", 48'h7820_0000, 3'd3, 1'b0);
    dec("r1_past", 48'h7840_0000, 3'd0, 1'b1);
    dec("r0_below", 48'h77FF_FFFF, 3'd0, 1'b1);

    // Overlap: lowest index wins, disabling hands over on the next capture
    wr_ok(12'h000, 32'h2000_0000); wr_ok(12'h008, 32'h0001_0000);
    wr_ok(12'h010, 32'h0000_0101);
    wr_ok(12'h060, 32'h2000_1000); wr_ok(12'h068, 32'h0000_1000);
    wr_ok(12'h070, 32'h0000_0501);
    dec("ovl_r0", 48'h2000_1800, 3'd1, 1'b0);
    wr_ok(12'h010, 32'h0000_0100);
    dec("ovl_r3", 48'h2000_1800, 3'd5, 1'b0);
    // Re-enable rule0 in the same cycle as a capture: that capture still sees the old table
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 12'h010; cfg_wdata = 32'h0000_0101;
    in_valid = 1'b1; in_addr = 48'h2000_1800;
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    check("same_cycle_idx", 64'(out_idx), 64'd5);
    check("same_cycle_cfg_err", 64'(cfg_err), 64'd0);
    dec("after_reenable", 48'h2000_1800, 3'd1, 1'b0);

    // Top of the address space and zero-size rules
    wr_ok(12'h040, 32'hFFFF_F000); wr_ok(12'h044, 32'h0000_FFFF);
    wr_ok(12'h048, 32'h0000_1000); wr_ok(12'h04C, 32'h0);
    wr_ok(12'h050, 32'h0000_0601);
    rd("r2_base_hi", 12'h044, 32'h0000_FFFF, 1'b0);
    dec("top_last", 48'hFFFF_FFFF_FFFF, 3'd6, 1'b0);
    dec("top_below", 48'hFFFF_FFFF_EFFF, 3'd0, 1'b1);
    wr_ok(12'h080, 32'h5000_0000); wr_ok(12'h090, 32'h0000_0701);
    dec("size_zero", 48'h5000_0000, 3'd0, 1'b1);

    // Backpressure: three back-to-back addresses, sink stalls two cycles
    @(posedge clk); #1;
    n0 = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 48'h7820_0010;
    @(posedge clk); #1;
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_idx", 64'(out_idx), 64'd3);
    check("bp_a_in_ready", 64'(in_ready), 64'd0);
    in_addr = 48'h2000_1800;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_idx", 64'(out_idx), 64'd3);
      check("bp_hold_err", 64'(out_err), 64'd0);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_b_idx", 64'(out_idx), 64'd1);
    check("bp_b_err", 64'(out_err), 64'd0);
    in_addr = 48'h10;
    @(posedge clk); #1;
    check("bp_c_idx", 64'(out_idx), 64'd0);
    check("bp_c_err", 64'(out_err), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_count", 64'(n_out - n0), 64'd3);

    // Lock
    wr_ok(12'h800, 32'h0);
    check("lock_zero_noop", 64'(locked), 64'd0);
    wr_ok(12'h800, 32'h1);
    check("locked", 64'(locked), 64'd1);
    wr("wr_locked", 12'h000, 32'h0000_1234, 1'b1);
    rd("rd_locked", 12'h000, 32'h2000_0000, 1'b0);
    rd("rd_lock_reg", 12'h800, 32'h1, 1'b0);
    wr_ok(12'h800, 32'h0);
    check("lock_sticky", 64'(locked), 64'd1);
    dec("dec_locked", 48'h2000_1800, 3'd1, 1'b0);

    // Miss counter saturation and clear-wins
    wr_ok(12'h804, 32'h0);
    rd("miss_cleared", 12'h804, 32'd0, 1'b0);
    in_valid  = 1'b1;
    in_addr   = 48'h10;
    out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rd("miss_sat", 12'h804, 32'h0000_FFFF, 1'b0);
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 12'h804; cfg_wdata = 32'h0;
    in_valid = 1'b1; in_addr = 48'h10;
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    check("clr_miss_cfg_err", 64'(cfg_err), 64'd0);
    check("clr_miss_out_err", 64'(out_err), 64'd1);
    rd("miss_clear_wins", 12'h804, 32'd0, 1'b0);
    dec("miss_after_clr", 48'h10, 3'd0, 1'b1);
    rd("miss_incr", 12'h804, 32'd1, 1'b0);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 48'h7820_0010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_before_rst", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drop_valid", 64'(out_valid), 64'd0);
    check("rst_drop_idx", 64'(out_idx), 64'd0);
    check("rst_unlock", 64'(locked), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    rd("rst_rule0_base", 12'h000, 32'h0, 1'b0);
    rd("rst_miss", 12'h804, 32'h0, 1'b0);
    dec("rst_table_empty", 48'h2000_1800, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/carfield_addr_map_rt.md
Name: carfield_addr_map_rt

Overview:
- Runtime-programmable address-map decoder: the next generation of the compile-time Carfield address configuration, with NumRules base/size/target rules held in registers instead of fixed parameters.
- Sits between a request source (e.g. crossbar address channel) and the demux select. Programmed over a 32-bit register port. Decodes a valid/ready stream of addresses into a target index plus an unmapped-error flag.
- Adds per-rule enable, a sticky lock and a saturating miss counter.

Parameters:
- NumRules, 8, number of programmable rules (1..32)
- AddrWidth, 48, decoded address width (33..64)
- NumTargets, 8, number of target ports; TgtW = $clog2(NumTargets)
- DefaultIdx, 0, index output on a miss

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_valid_i  in  1  register access request
- cfg_ready_o  out  1  always 1 (access accepted same cycle)
- cfg_we_i  in  1  write enable
- cfg_addr_i  in  12  byte offset, word aligned
- cfg_wdata_i  in  32  write data
- cfg_rvalid_o  out  1  response valid, one cycle after acceptance
- cfg_rdata_o  out  32  read data, 0 on writes or errors
- cfg_err_o  out  1  response error
- in_valid_i  in  1  address valid
- in_ready_o  out  1  address ready
- in_addr_i  in  AddrWidth  address to decode
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result ready
- out_idx_o  out  TgtW  selected target
- out_err_o  out  1  no rule matched
- locked_o  out  1  configuration locked

Behaviour:
- Reset (async, rst_i=1):
  - all rules have base=0, size=0, en=0, tgt=0; lock=0; miss_cnt=0.
  - out_valid_o=0, out_idx_o=0, out_err_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0, locked_o=0.
  - Reset mid-transfer drops any held result.
- Register map, rule r at r*0x20:
  - +0x00 base[31:0]; +0x04 base[AddrWidth-1:32], upper bits read 0.
  - +0x08 size[31:0]; +0x0C size high.
  - +0x10 ctrl: bit0 en, bits[8+:TgtW] tgt.
- Global registers:
  - 0x800 LOCK: write bit0=1 sets lock; writing 0 has no effect.
  - 0x804 MISS_CNT: 16-bit; any write clears it.
  - 0x808 NUM_RULES: read-only, returns NumRules.
- Access errors:
  - Unmapped offset, or rule index >= NumRules: cfg_err_o=1, no state change.
  - A write to rule registers while lock=1: cfg_err_o=1, ignored. Reads stay legal.
  - Writes to NUM_RULES: error.
- Config response: registered, exactly one cycle after cfg_valid_i.
- Match condition, rule r matches when all hold:
  - en=1 and size!=0
  - addr >= base
  - addr < base+size, evaluated in AddrWidth+1 bits, so the sum never wraps; a rule may reach 2^AddrWidth.
  - size=0 never matches.
- Priority: the lowest-index matching rule wins. Overlaps are legal.
- Miss: out_idx_o=DefaultIdx, out_err_o=1.
- tgt >= NumTargets: out_idx_o=DefaultIdx, out_err_o=1, counted as a miss.
- Pipeline: single-stage output register, latency 1 cycle.
  - in_ready_o = !out_valid_o || out_ready_i, so full throughput with no bubbles.
  - On in_valid_i && in_ready_o, the decoded result is captured and out_valid_o=1 next cycle.
  - out_idx_o and out_err_o are held stable while out_valid_o && !out_ready_i.
- Miss counter: increments on capture of a miss result. It saturates at 0xFFFF.
  - Simultaneous capture-miss and MISS_CNT write: the clear wins, and the value becomes 0.
- Config/decode ordering: the decode uses the table state in the capture cycle. A rule write accepted in cycle t affects addresses captured in cycle t+1 onward.
- locked_o mirrors lock; only reset clears it.

Test Plan:
- Reset -> all outputs 0. NUM_RULES reads 8. Any address decodes to idx 0 with err=1, and MISS_CNT=1 after one request.
- Program rule0: base 0x78000000, size 0x200000, tgt 2, en. Program rule1: base 0x78200000, same size, tgt 3. Addresses 0x781FFFFF -> idx2; 0x78200000 -> idx3; 0x78400000 -> DefaultIdx with err=1.
- Overlap: rule0 0x20000000/0x10000 tgt1, rule3 0x20001000/0x1000 tgt5. 0x20001800 -> idx1. Disable rule0 -> idx5 from the next capture.
- Top of space: base 0xFFFF_FFFF_F000, size 0x1000. 0xFFFF_FFFF_FFFF matches. size=0 at any base never matches.
- Backpressure: 3 back-to-back addresses with out_ready_i low 2 cycles. Outputs held stable, in_ready_o=0 while stalled, no result lost or duplicated.
- Lock: write LOCK=1, then write rule0 base -> cfg_err_o=1, value unchanged. Read still OK. MISS_CNT saturates at 0xFFFF after 65540 misses, and a write clears it to 0 even when it coincides with a miss.
